// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, and stalls on the memory ready handshake.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic [2:0]         Func3,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic [2:0]         ImmSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  // Memory handshake: MemReady=1 in FETCH, MEM_READ or MEM_WRITE completes the
  // access in that cycle; in every other state MemReady is ignored.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR1     = 4'd11,
    S_JALR2     = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       pc_jump;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   taken;
  logic   fetch_done;

  function automatic ctrl_t moore(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEM_ADDR:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.adr_src = 1'b1; end
      S_MEM_WB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXEC_R:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
      S_EXEC_I:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALU_WB:    c.reg_write = 1'b1;
      S_BRANCH:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b11; end
      S_JAL, S_JALR2: begin c.pc_jump = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      S_JALR1:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_LUI:       begin c.result_src = 2'b11; c.reg_write = 1'b1; end
      S_TRAP:      c.illegal = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:     nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          7'b0000011, 7'b0100011: nxt = S_MEM_ADDR;
          7'b0110011:             nxt = S_EXEC_R;
          7'b0010011:             nxt = S_EXEC_I;
          7'b1100011:             nxt = S_BRANCH;
          7'b1101111:             nxt = S_JAL;
          7'b1100111:             nxt = S_JALR1;
          7'b0110111:             nxt = S_LUI;
          default:                nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  nxt = Op[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  nxt = MemReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = MemReady ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR2: nxt = S_ALU_WB;
      S_JALR1:     nxt = S_JALR2;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_FETCH;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with State.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      ctrl_q <= moore(S_FETCH);
    end else begin
      state  <= nxt;
      ctrl_q <= moore(nxt);
    end
  end

  always_comb begin
    case (Func3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = ~Zero;
      3'b101:  taken = Zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (Op)
      7'b0100011: ImmSrc = 3'b001;
      7'b1100011: ImmSrc = 3'b010;
      7'b1101111: ImmSrc = 3'b011;
      7'b0110111: ImmSrc = 3'b100;
      default:    ImmSrc = 3'b000;
    endcase
  end

  // Write strobes are suppressed while rst is high so an aborted instruction
  // cannot commit anything in the reset cycle.
  assign fetch_done = (state == S_FETCH) && MemReady;
  assign PCWrite    = ~rst & (ctrl_q.pc_jump | fetch_done | ((state == S_BRANCH) & taken));
  assign IRWrite    = ~rst & fetch_done;
  assign MemWrite   = ~rst & ctrl_q.mem_write;
  assign RegWrite   = ~rst & ctrl_q.reg_write;
  assign MemRead    = ctrl_q.mem_read;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUOp      = ctrl_q.alu_op;
  assign Illegal    = ctrl_q.illegal;
  assign State      = STATE_W'(state);

endmodule
